// File: rtl/myproject_mac_pipe.sv
// Pipelined signed MAC: term at edge n reaches acc at n+NUM_STAGE, group result valid after n+NUM_STAGE+1.
// Always ready (no backpressure); ce=0 freezes every register, so out_valid must be qualified with ce.
module myproject_mac_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 11,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 3,
  parameter int ACC_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 16,
  parameter int SHIFT       = 10,
  parameter int ROUND       = 1,
  parameter int SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic signed [ACC_WIDTH:0] ONE  = 1;
  localparam logic signed [ACC_WIDTH:0] RND  = (ROUND != 0) ? ((ONE << SHIFT) >> 1) : '0;
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [DIN1_WIDTH:0] din1_ext;
  logic signed [PW-1:0]       mul_a, mul_b, prod;

  // The full product always fits in PW bits, so multiplying at PW bits is exact.
  always_comb begin
    din1_ext = (DIN1_SIGNED != 0) ? $signed({din1[DIN1_WIDTH-1], din1})
                                  : $signed({1'b0, din1});
    mul_a    = PW'($signed(din0));
    mul_b    = PW'(din1_ext);
    prod     = mul_a * mul_b;
  end

  logic signed [PW-1:0] pipe_dat [NUM_STAGE];
  logic [NUM_STAGE-1:0] pipe_vld, pipe_lst;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pipe_vld <= '0;
      pipe_lst <= '0;
      for (int i = 0; i < NUM_STAGE; i++) pipe_dat[i] <= '0;
    end else if (ce) begin
      pipe_dat[0] <= prod;
      pipe_vld[0] <= in_valid;
      pipe_lst[0] <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        pipe_dat[i] <= pipe_dat[i-1];
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_lst[i] <= pipe_lst[i-1];
      end
    end
  end

  logic                        tail_vld, tail_lst, add_ovf;
  logic signed [ACC_WIDTH-1:0] term, sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        acc_ovf, first, acc_done;

  always_comb begin
    tail_vld = pipe_vld[NUM_STAGE-1];
    tail_lst = pipe_lst[NUM_STAGE-1];
    term     = ACC_WIDTH'(pipe_dat[NUM_STAGE-1]);
    sum      = acc + term;
    add_ovf  = (acc[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  end

  // acc_done marks that acc holds a completed group for the output stage next edge.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      first    <= 1'b1;
      acc_done <= 1'b0;
    end else if (ce) begin
      acc_done <= tail_vld & tail_lst;
      if (tail_vld) begin
        if (first) begin
          acc     <= term;
          acc_ovf <= 1'b0;
        end else begin
          acc     <= sum;
          acc_ovf <= acc_ovf | add_ovf;
        end
        first <= tail_lst;
      end
    end
  end

  logic signed [ACC_WIDTH:0] rnd_sum, shifted;
  logic [DOUT_WIDTH-1:0]     res_dat;
  logic                      clamp;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    rnd_sum = $signed({acc[ACC_WIDTH-1], acc}) + RND;
    shifted = rnd_sum >>> SHIFT;
    res_dat = shifted[DOUT_WIDTH-1:0];
    clamp   = 1'b0;
    if (SATURATE != 0) begin
      if (shifted > MAXV) begin
        res_dat = MAXV[DOUT_WIDTH-1:0];
        clamp   = 1'b1;
      end else if (shifted < MINV) begin
        res_dat = MINV[DOUT_WIDTH-1:0];
        clamp   = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= acc_done;
      if (acc_done) begin
        dout <= res_dat;
        ovf  <= acc_ovf | clamp;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: default, non-saturating and signed-din1 instances share stimulus.
module tb_myproject_mac_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] din0 = '0;
  logic [10:0] din1 = '0;

  logic        ov_d, ovf_d, ov_n, ovf_n, ov_s, ovf_s;
  logic [15:0] dout_d, dout_n, dout_s;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int cyc, t0, seen;

  always #5 ap_clk = ~ap_clk;

  myproject_mac_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(ov_d), .dout(dout_d), .ovf(ovf_d)
  );

  myproject_mac_pipe #(.SATURATE(0)) u_nosat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(ov_n), .dout(dout_n), .ovf(ovf_n)
  );

  myproject_mac_pipe #(.DIN1_SIGNED(1), .SHIFT(0)) u_sgn (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(ov_s), .dout(dout_s), .ovf(ovf_s)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
    ncyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic term(input logic [15:0] a, input logic [10:0] b, input logic l);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    din0     = '0;
    din1     = '0;
  endtask

  task automatic wait_res(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ov_d && n < 30);
    chk({tag, "_timeout"}, 32'(ov_d), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", 32'(ov_d), 32'd0);
    chk("rst_dout", 32'(dout_d), 32'd0);
    chk("rst_ovf", 32'(ovf_d), 32'd0);
    ap_rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(ov_d), 32'd0);

    // Single-term group -3 x 2047
    term(16'hFFFD, 11'd2047, 1'b1);
    wait_res("t1", cyc);
    chk("t1_latency", 32'(cyc), 32'd4);
    chk("t1_dout", 32'(dout_d), 32'h0000FFFA);
    chk("t1_ovf", 32'(ovf_d), 32'd0);
    tick();
    chk("t1_single_pulse", 32'(ov_d), 32'd0);

    // Four terms of 1000 x 1024 with 2-cycle gaps
    t0 = ncyc;
    for (int k = 0; k < 4; k++) begin
      term(16'd1000, 11'd1024, k == 3);
      if (k < 3) repeat (2) tick();
    end
    wait_res("t2", cyc);
    chk("t2_latency", 32'(ncyc - t0), 32'd14);
    chk("t2_dout", 32'(dout_d), 32'd4000);
    chk("t2_ovf", 32'(ovf_d), 32'd0);
    tick();
    chk("t2_single_result", 32'(ov_d), 32'd0);

    // Saturation and wrap
    term(16'h7FFF, 11'd2047, 1'b0);
    term(16'h7FFF, 11'd2047, 1'b1);
    wait_res("t3a", cyc);
    chk("t3_pos_sat_dout", 32'(dout_d), 32'h00007FFF);
    chk("t3_pos_sat_ovf", 32'(ovf_d), 32'd1);
    chk("t3_wrap_valid", 32'(ov_n), 32'd1);
    chk("t3_wrap_dout", 32'(dout_n), 32'h0000FFBC);
    chk("t3_wrap_ovf", 32'(ovf_n), 32'd0);
    term(16'h8000, 11'd2047, 1'b1);
    wait_res("t3b", cyc);
    chk("t3_neg_sat_dout", 32'(dout_d), 32'h00008000);
    chk("t3_neg_sat_ovf", 32'(ovf_d), 32'd1);

    // Back-to-back single-term groups
    term(16'd1000, 11'd1024, 1'b1);
    term(16'd2000, 11'd1024, 1'b1);
    wait_res("t4", cyc);
    chk("t4_a_latency", 32'(cyc), 32'd3);
    chk("t4_a_dout", 32'(dout_d), 32'd1000);
    tick();
    chk("t4_b_valid", 32'(ov_d), 32'd1);
    chk("t4_b_dout", 32'(dout_d), 32'd2000);
    tick();
    chk("t4_end_valid", 32'(ov_d), 32'd0);

    // Signed din1 (-1) with SHIFT=0; default instance rounds 100*2047
    term(16'd100, 11'h7FF, 1'b1);
    wait_res("t5a", cyc);
    chk("t5_sgn_valid", 32'(ov_s), 32'd1);
    chk("t5_sgn_dout", 32'(dout_s), 32'h0000FF9C);
    chk("t5_sgn_ovf", 32'(ovf_s), 32'd0);
    chk("t5_round_dout", 32'(dout_d), 32'd200);

    // Four-term group with a 5-cycle ce stall mid-group
    t0 = ncyc;
    term(16'd1000, 11'd1024, 1'b0);
    repeat (2) tick();
    term(16'd1000, 11'd1024, 1'b0);
    ce = 1'b0;
    repeat (5) tick();
    ce = 1'b1;
    repeat (2) tick();
    term(16'd1000, 11'd1024, 1'b0);
    repeat (2) tick();
    term(16'd1000, 11'd1024, 1'b1);
    wait_res("t5b", cyc);
    chk("t5_ce_latency", 32'(ncyc - t0), 32'd19);
    chk("t5_ce_dout", 32'(dout_d), 32'd4000);

    // ce=0 freezes a presented result
    term(16'd1000, 11'd1024, 1'b1);
    wait_res("t7", cyc);
    ce = 1'b0;
    repeat (3) tick();
    chk("t7_frozen_valid", 32'(ov_d), 32'd1);
    chk("t7_frozen_dout", 32'(dout_d), 32'd1000);
    ce = 1'b1;
    tick();
    chk("t7_released_valid", 32'(ov_d), 32'd0);

    // Reset mid-group discards the partial group
    term(16'd1000, 11'd1024, 1'b0);
    repeat (2) tick();
    term(16'd1000, 11'd1024, 1'b0);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (ov_d) seen++;
    end
    chk("t6_no_output", 32'(seen), 32'd0);
    term(16'd1000, 11'd1024, 1'b1);
    wait_res("t6", cyc);
    chk("t6_dout", 32'(dout_d), 32'd1000);
    chk("t6_ovf", 32'(ovf_d), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/myproject_mac_pipe.md
# myproject_mac_pipe

Parametrised, pipelined multiply-accumulate unit: the successor of the fixed-width combinational multiplier primitives in the generated kernel. It multiplies a signed `din0` by a signed or unsigned `din1` through a configurable register pipeline and accumulates products over a group of terms delimited by `in_last`. It then emits one rounded, right-shifted, saturated result per group. It sits in the dense/attention dot-product datapath of the HEPT kernel, where it replaces a multiplier plus an external adder tree.

## Interface
- `DIN0_WIDTH`, default 16: width of `din0`, always signed.
- `DIN1_WIDTH`, default 11: width of `din1`.
- `DIN1_SIGNED`, default 0: 0 treats `din1` as unsigned (zero-extended by 1 bit); 1 treats it as signed.
- `NUM_STAGE`, default 3: product register stages, legal range 1..4.
- `ACC_WIDTH`, default 32: accumulator width. Must be at least `DIN0_WIDTH+DIN1_WIDTH`.
- `DOUT_WIDTH`, default 16: output width, signed.
- `SHIFT`, default 10: arithmetic right shift applied to the accumulator at output. Legal range 0..`ACC_WIDTH-1`.
- `ROUND`, default 1: 1 rounds half-up before the shift; 0 truncates.
- `SATURATE`, default 1: 1 clamps to the `DOUT_WIDTH` signed range; 0 wraps.

Ports (name, direction, width, meaning):
- `ap_clk` in 1: single clock, rising edge.
- `ap_rst_n` in 1: synchronous, active-low reset.
- `ce` in 1: clock enable. When low, every register holds.
- `in_valid` in 1: `din0`/`din1`/`in_last` are valid this cycle.
- `din0` in `DIN0_WIDTH`: multiplicand.
- `din1` in `DIN1_WIDTH`: multiplier.
- `in_last` in 1: this term closes the current group.
- `out_valid` out 1: `dout`/`ovf` hold a group result.
- `dout` out `DOUT_WIDTH`: group result.
- `ovf` out 1: an overflow occurred in the reported group.

## Operation
**Product.** P = `DIN0_WIDTH+DIN1_WIDTH` bits.
- The product is computed as signed(din0) × signed({0,din1}) when `DIN1_SIGNED`=0, or as signed(din0) × signed(din1) when `DIN1_SIGNED`=1.
- It is sign-extended to `ACC_WIDTH` after the last product stage.

**Pipeline.**
- There are `NUM_STAGE` product registers. Each carries `valid` and `last` sideband bits alongside the product.
- The first product register also captures the inputs; the input is not registered separately.

**Accumulator (one register stage).** A `first` flag is set at reset and set again after any `last` term is consumed. On a valid product:
- If `first`=1: acc = product and acc_ovf = 0.
- Otherwise: acc = acc + product, wrapping in two's complement. acc_ovf is set if the signed add overflows.
- `first` is cleared on non-last terms and set on last terms.
- Invalid pipeline slots (bubbles) leave acc and `first` unchanged.

**Output (one register stage).** Updated only when a valid, last product is accumulated.
- t = (acc_next + (`ROUND` ? 2^(`SHIFT`-1) : 0)) >>> `SHIFT`. The rounding term is 0 when `SHIFT`=0. This is computed at `ACC_WIDTH`+1 bits so the rounding add cannot wrap.
- With `SATURATE`=1, t is clamped to [-2^(`DOUT_WIDTH`-1), 2^(`DOUT_WIDTH`-1)-1]. With `SATURATE`=0, the low `DOUT_WIDTH` bits are kept.
- `ovf` = acc_ovf_next OR clamp_applied.
- `out_valid` pulses for exactly one `ce`-enabled cycle per group.

**Groups.**
- Groups may be of any length ≥1, including single-term groups.
- Groups may be back-to-back: a new first term may arrive the cycle after the `in_last` term, with no bubble required.
- `in_valid` gaps inside a group are allowed.

**Reset.** While `ap_rst_n`=0 at a rising edge:
- All valid/last sideband bits, `out_valid` and `ovf` are set to 0. `dout`, acc and product registers are set to 0. `first` is set to 1.
- Any partial group in flight is discarded with no output.

**Clock enable.**
- `ce`=0 freezes all state, including `out_valid`, `dout` and `ovf`.
- Downstream logic must qualify `out_valid` with `ce`.
- Reset takes priority over `ce`.

## Timing
- A term sampled at enabled edge n (`in_valid`=1) reaches the accumulator at edge n+`NUM_STAGE`.
- If that term is last, `out_valid` is high after edge n+`NUM_STAGE`+1. This is edge n+4 at the default parameters.
- Latency is counted in `ce`-enabled edges only.
- Throughput is one term per cycle with no backpressure; the block is always ready.
- The minimum spacing between results is 1 cycle, for consecutive single-term groups.
- In the cycle after reset is released, `out_valid`=0. An input may be accepted on the first edge with `ap_rst_n`=1.

## Test plan
All scenarios use default parameters unless a line states otherwise.

1. Single-term group: `din0`=-3 (0xFFFD), `din1`=2047, `in_last`=1 at edge n. Required: `out_valid`=1 only after edge n+4, `dout`=-6 (0xFFFA), `ovf`=0.
2. Four-term group: `din0`=1000 and `din1`=1024 on every term, with 2-cycle `in_valid` gaps between terms and `in_last` on the 4th term. Required: a single result with `dout`=4000 and `ovf`=0.
3. Saturation: two terms of 32767×2047 → `dout`=32767, `ovf`=1. One term of -32768×2047 → `dout`=-32768, `ovf`=1. `SATURATE`=0 repeat of the positive case → `dout`=0xFFBC and `ovf`=0.
4. Back-to-back groups: group A (one term, 1000×1024) then group B (one term, 2000×1024) on the next cycle. Required: `dout`=1000 then 2000 on consecutive cycles, with no carry of A into B.
5. Signed mode and `ce`:
   - `DIN1_SIGNED`=1, `din0`=100, `din1`=0x7FF (-1), `SHIFT`=0 → `dout`=-100.
   - Scenario 2 repeated with `ce`=0 for 5 cycles mid-group → identical result, delivered 5 cycles later.
6. Reset mid-group: deassert `ap_rst_n` for 1 edge after 2 terms of scenario 2 have been sent. Required: no `out_valid` for the aborted group. A following one-term group of 1000×1024 returns `dout`=1000.
